shift_right_seq: RTL

- Iterative right shifter for the multi-cycle datapath.
- Executes srl, sra, srlv and srav by shifting the operand right one bit per cycle under a start/done handshake.
- It is the counterpart of the combinational left-shift-by-2 used in branch/jump address formation; it sits beside the ALU.
- The control FSM holds the current instruction state until done.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_right_step.sv | 38 +++
 rtl/shift_right_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_pkg
// Description : Shared constants for the iterative right shifter:
//               - default operand and shift-amount widths
//               - FSM state encoding
//               - multi-bit step size used by SHIFT_RIGHT_SEQ_FAST_EN builds
// Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  // Largest step taken in one SHIFT cycle when the fast mode is built in.
  localparam int FAST_STEP   = 4;
  // Wide enough to hold any step amount in 1..FAST_STEP.
  localparam int STEP_W      = $clog2(FAST_STEP + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_right_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_step
// Description : Combinational single-step right shifter.
//               Shifts data_i right by amt_i bits, where amt_i is 1..FAST_STEP.
//               Vacated bits are filled with data_i's sign bit when arith_i=1,
//               and with 0 otherwise.
// Ports       : data_i  [WIDTH]  operand
//               arith_i          1 = sign fill, 0 = zero fill
//               amt_i   [STEP_W] step amount (1..FAST_STEP)
//               data_o  [WIDTH]  shifted result
// Revision    : 1.0 - initial release
// ============================================================================
module shift_right_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]  data_i,
  input  logic              arith_i,
  input  logic [STEP_W-1:0] amt_i,
  output logic [WIDTH-1:0]  data_o
);

  logic                       w_fill;
  logic [WIDTH+FAST_STEP-1:0] w_ext;
  logic [WIDTH+FAST_STEP-1:0] w_shifted;

  // Prepend FAST_STEP copies of the fill bit. A logical shift of the extended
  // word then pulls the correct fill into the top of the low WIDTH bits for
  // any step amount up to FAST_STEP.
  assign w_fill    = arith_i & data_i[WIDTH-1];
  assign w_ext     = {{FAST_STEP{w_fill}}, data_i};
  assign w_shifted = w_ext >> amt_i;
  assign data_o    = w_shifted[WIDTH-1:0];

endmodule : shift_right_step
`default_nettype wire

// File: rtl/shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_seq
// Description : Iterative right shifter (srl/sra/srlv/srav) for the
//               multi-cycle datapath. The shifter accepts a request with
//               start while idle. It shifts the operand right under FSM
//               control and pulses done when out_data holds the result.
// Ports       : clk              rising-edge clock
//               reset            synchronous active-high reset
//               start            request, sampled only while idle
//               in_data [WIDTH]  operand
//               shamt [SHAMT_W]  shift amount
//               arith            1 = arithmetic, 0 = logical
//               busy             high during the SHIFT state
//               done             one-cycle pulse, out_data valid
//               out_data [WIDTH] result, held until the next result
// Config      : SHIFT_RIGHT_SEQ_FAST_EN - when defined, each SHIFT cycle
//               shifts by min(FAST_STEP, count) bits instead of one. The
//               results are identical in both builds; only latency changes.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_right_seq
  import shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out_data
);

  if (2 ** SHAMT_W != WIDTH) begin : g_bad_cfg
    $error("shift_right_seq: 2**SHAMT_W must equal WIDTH");
  end

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               arith_q;
  logic [WIDTH-1:0]   out_q;

  logic [STEP_W-1:0]  w_step_amt;
  logic [WIDTH-1:0]   w_step_data;
  logic               w_last;
  logic               w_enter_done;

`ifdef SHIFT_RIGHT_SEQ_FAST_EN
  localparam logic [SHAMT_W-1:0] c_fast = SHAMT_W'(FAST_STEP);

  // Take a full step until the remainder fits in one step, then finish it.
  assign w_step_amt = (count_q > c_fast) ? STEP_W'(FAST_STEP)
                                         : count_q[STEP_W-1:0];
  assign w_last     = (count_q <= c_fast);
`else
  assign w_step_amt = STEP_W'(1);
  assign w_last     = (count_q == SHAMT_W'(1));
`endif

  shift_right_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i  (work_q),
    .arith_i (arith_q),
    .amt_i   (w_step_amt),
    .data_o  (w_step_data)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy     = (state_q == ST_SHIFT);
    done     = (state_q == ST_DONE);
    out_data = out_q;
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_comb begin
    work_d  = work_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = in_data;
          count_d = shamt;
        end
      end
      ST_SHIFT: begin
        work_d  = w_step_data;
        count_d = count_q - SHAMT_W'(w_step_amt);
      end
      default: ;
    endcase
  end

  // The result register loads on the edge that enters DONE. Loading work_d
  // covers both paths: a zero shift directly from IDLE, where work_d is
  // in_data, and the final step out of SHIFT.
  assign w_enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q  <= '0;
      count_q <= '0;
      arith_q <= 1'b0;
      out_q   <= '0;
    end else begin
      work_q  <= work_d;
      count_q <= count_d;
      if (state_q == ST_IDLE && start) begin
        arith_q <= arith;
      end
      if (w_enter_done) begin
        out_q <= work_d;
      end
    end
  end

endmodule : shift_right_seq
`default_nettype wire
